// File: rtl/branch_predict_ctrl_if.sv
// Predictor <-> core signal bundle: ID lookup/push, EX2 resolve, and status.
// The stat_* signals exist only when BP_STATS_EN is defined.
interface branch_predict_ctrl_if #(
  parameter int unsigned QDEPTH = 2
);
  logic                      id_is_branch;
  logic [31:0]               id_pc;
  logic                      id_advance;
  logic                      pred_taken;
  logic                      q_full;
  logic                      ex_resolve;
  logic                      ex_taken;
  logic                      mispredict;
  logic [$clog2(QDEPTH):0]   q_count;
  logic                      underflow_err;
`ifdef BP_STATS_EN
  logic [15:0]               stat_branches;
  logic [15:0]               stat_mispredicts;
`endif

  modport master (
    output id_is_branch, id_pc, id_advance, ex_resolve, ex_taken,
    input  pred_taken, q_full, mispredict, q_count, underflow_err
`ifdef BP_STATS_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  id_is_branch, id_pc, id_advance, ex_resolve, ex_taken,
    output pred_taken, q_full, mispredict, q_count, underflow_err
`ifdef BP_STATS_EN
    , output stat_branches, stat_mispredicts
`endif
  );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter branch predictor with an in-flight prediction FIFO.
// Define BP_STATS_EN to add saturating branch/mispredict statistics counters.
module branch_predict_ctrl #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned QDEPTH  = 2
) (
  input logic                  clk,
  input logic                  rst,
  branch_predict_ctrl_if.slave bp
);
  localparam int unsigned Entries = 1 << INDEX_W;
  localparam int unsigned PtrW    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW    = $clog2(QDEPTH) + 1;

  logic [1:0]         ctr_tbl    [Entries];
  logic [INDEX_W-1:0] fifo_idx_q [QDEPTH];
  logic               fifo_pred_q[QDEPTH];
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               underflow_q;

  logic [INDEX_W-1:0] lookup_idx;
  logic [INDEX_W-1:0] head_idx;
  logic               full;
  logic               push;
  logic               pop;
  logic               mispred;
  logic               unused_pc;

  assign unused_pc  = ^bp.id_pc[31:INDEX_W];
  assign lookup_idx = bp.id_pc[INDEX_W-1:0];
  assign head_idx   = fifo_idx_q[rd_ptr_q];
  assign full       = (count_q == CntW'(QDEPTH));
  assign push       = bp.id_is_branch & bp.id_advance & ~full;
  assign pop        = bp.ex_resolve & (count_q != '0);
  assign mispred    = pop & (fifo_pred_q[rd_ptr_q] ^ bp.ex_taken);

  // Lookup reads the registered table, so a same-cycle update is not bypassed.
  assign bp.pred_taken    = bp.id_is_branch & ctr_tbl[lookup_idx][1];
  assign bp.q_full        = full;
  assign bp.mispredict    = mispred;
  assign bp.q_count       = count_q;
  assign bp.underflow_err = underflow_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx_q[wr_ptr_q]  <= lookup_idx;
      fifo_pred_q[wr_ptr_q] <= bp.pred_taken;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      if (bp.ex_resolve && count_q == '0) underflow_q <= 1'b1;
      // A mispredict squashes every younger entry, including a same-cycle push.
      if (mispred) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(Entries); i++) ctr_tbl[i] <= 2'd1;
    end else if (pop) begin
      if (bp.ex_taken) begin
        if (ctr_tbl[head_idx] != 2'd3) ctr_tbl[head_idx] <= ctr_tbl[head_idx] + 2'd1;
      end else begin
        if (ctr_tbl[head_idx] != 2'd0) ctr_tbl[head_idx] <= ctr_tbl[head_idx] - 2'd1;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [15:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (pop && stat_br_q != 16'hFFFF)      stat_br_q  <= stat_br_q + 16'd1;
      if (mispred && stat_mis_q != 16'hFFFF) stat_mis_q <= stat_mis_q + 16'd1;
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_branch_predict_ctrl;
  localparam int QDEPTH = 2;

  logic clk;
  logic rst;

  branch_predict_ctrl_if #(.QDEPTH(QDEPTH)) bus ();

  branch_predict_ctrl #(
    .INDEX_W(6),
    .QDEPTH (QDEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bp (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] idx;
    logic       pred;
  } ent_t;

  int   ctr[64];
  ent_t q[$];
  bit   uf;
  int   checks;
  int   passes;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ctr[i] = 1;
    q.delete();
    uf = 1'b0;
  endtask

  // Drive one cycle, check combinational/state outputs, then advance the model.
  task automatic cycle(input bit br, input logic [31:0] pc, input bit adv,
                       input bit res, input bit tk);
    bit   e_pred, e_full, e_mis;
    int   e_cnt;
    ent_t h;
    logic [5:0] idx;
    @(negedge clk);
    bus.id_is_branch = br;
    bus.id_pc        = pc;
    bus.id_advance   = adv;
    bus.ex_resolve   = res;
    bus.ex_taken     = tk;
    #1;
    idx    = pc[5:0];
    e_pred = br && (ctr[idx] >= 2);
    e_cnt  = q.size();
    e_full = (e_cnt == QDEPTH);
    e_mis  = res && (e_cnt > 0) && (q[0].pred != tk);
    chk("pred_taken", 32'(bus.pred_taken), 32'(e_pred));
    chk("q_full", 32'(bus.q_full), 32'(e_full));
    chk("q_count", 32'(bus.q_count), 32'(e_cnt));
    chk("mispredict", 32'(bus.mispredict), 32'(e_mis));
    chk("underflow_err", 32'(bus.underflow_err), 32'(uf));
    @(posedge clk);
    if (res && e_cnt == 0) uf = 1'b1;
    if (res && e_cnt > 0) begin
      h = q.pop_front();
      if (tk) ctr[h.idx] = (ctr[h.idx] == 3) ? 3 : ctr[h.idx] + 1;
      else    ctr[h.idx] = (ctr[h.idx] == 0) ? 0 : ctr[h.idx] - 1;
      if (e_mis) q.delete();
    end
    if (br && adv && !e_full && !e_mis) q.push_back('{idx: idx, pred: e_pred});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.id_is_branch = 1'b0;
    bus.id_advance   = 1'b0;
    bus.ex_resolve   = 1'b0;
    bus.ex_taken     = 1'b0;
    #1;
    chk("rst_q_count", 32'(bus.q_count), 32'd0);
    chk("rst_underflow", 32'(bus.underflow_err), 32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst_pred", 32'(bus.pred_taken), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    bit br, adv, res, tk;
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.id_is_branch = 1'b0;
    bus.id_pc        = '0;
    bus.id_advance   = 1'b0;
    bus.ex_resolve   = 1'b0;
    bus.ex_taken     = 1'b0;
    model_reset();
    #2;
    do_reset();

    // Weak-NT start, mispredicted taken, then predicted taken.
    cycle(1, 32'h10, 1, 0, 0);
    cycle(0, 32'h0, 0, 1, 1);
    cycle(1, 32'h10, 0, 0, 0);

    // Saturate index 5 upward, then walk back down two steps.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'h5, 1, 0, 0);
      cycle(0, 32'h0, 0, 1, 1);
    end
    cycle(1, 32'h5, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      cycle(1, 32'h5, 1, 0, 0);
      cycle(0, 32'h0, 0, 1, 0);
    end
    cycle(1, 32'h5, 0, 0, 0);

    // Fill the FIFO, hold ID, then drain with correct outcomes.
    cycle(1, 32'h20, 1, 0, 0);
    cycle(1, 32'h21, 1, 0, 0);
    cycle(1, 32'h22, 0, 0, 0);
    cycle(1, 32'h22, 1, 0, 0);
    cycle(0, 32'h0, 0, 1, 0);
    cycle(0, 32'h0, 0, 1, 0);
    cycle(0, 32'h0, 0, 0, 0);

    // Head mispredicts while a push is attempted.
    cycle(1, 32'h30, 1, 0, 0);
    cycle(1, 32'h31, 1, 0, 0);
    cycle(1, 32'h32, 1, 1, 1);
    cycle(1, 32'h31, 0, 0, 0);

    // Resolve with an empty FIFO sets the sticky error.
    cycle(0, 32'h0, 0, 1, 1);
    cycle(0, 32'h0, 0, 0, 0);
    cycle(1, 32'h10, 0, 0, 0);
    do_reset();
    cycle(1, 32'h10, 0, 0, 0);
    cycle(1, 32'h5, 0, 0, 0);

    // Same-index lookup and update in one cycle: no bypass.
    cycle(1, 32'h3, 1, 0, 0);
    cycle(1, 32'h3, 1, 1, 1);
    cycle(1, 32'h3, 0, 0, 0);

    // Random traffic over a few aliasing indices.
    for (int i = 0; i < 600; i++) begin
      if (i % 200 == 199) do_reset();
      pc       = $urandom;
      pc[5:0]  = 6'($urandom_range(0, 3));
      br       = ($urandom_range(0, 3) != 0);
      adv      = (q.size() < QDEPTH) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      res      = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 40) == 0);
      tk       = ($urandom_range(0, 2) != 0);
      cycle(br, pc, adv, res, tk);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
- Dynamic branch-direction predictor and in-flight prediction tracker for the pipelined RISC-V core.
- Sits beside the decode stage. It supplies the taken/not-taken prediction for beq/bne in ID and records each prediction in a small FIFO.
- When the branch resolves at the end of EX2, it retires the matching entry, updates a 2-bit saturating counter table and flags mispredictions to the flush/PC-select logic.

Parameters:
- INDEX_W, 6, counter-table index width; table has 2^INDEX_W entries indexed by pc[INDEX_W-1:0].
- QDEPTH, 2, in-flight prediction FIFO depth (covers the EX1 and EX2 stages); power of two, ≥2.

Ports:
- clk  input  1  core clock, all state updates on rising edge.
- rst  input  1  asynchronous active-low reset.
- id_is_branch  input  1  decoded instruction in ID is beq or bne.
- id_pc  input  32  PC of the instruction in ID.
- id_advance  input  1  ID instruction moves to EX1 this cycle (IF_ID_write and no ID flush).
- pred_taken  output  1  prediction for the ID branch; 0 when id_is_branch=0.
- q_full  output  1  FIFO holds QDEPTH entries; the stall unit must hold ID.
- ex_resolve  input  1  oldest in-flight branch resolves this cycle.
- ex_taken  input  1  actual outcome of the resolving branch.
- mispredict  output  1  resolving branch was mispredicted (combinational, same cycle as ex_resolve).
- q_count  output  $clog2(QDEPTH)+1  current FIFO occupancy.
- underflow_err  output  1  sticky: ex_resolve asserted while FIFO was empty.

Behaviour:
- Counter encoding: 0=strong NT, 1=weak NT, 2=weak T, 3=strong T.
- pred_taken = id_is_branch & table[id_pc[INDEX_W-1:0]][1]. Combinational, zero latency.
- Reset (rst=0, asynchronous):
  - All counters reset to 1 (weak NT).
  - FIFO read/write pointers and count reset to 0.
  - underflow_err=0; mispredict=0; pred_taken=0 (follows from id_is_branch gating).
  - Reset asserted mid-operation discards all in-flight entries; no counter update completes.
- Push: on the clock edge when id_is_branch & id_advance & !q_full, write {index, pred_taken} at the tail.
  - A push attempted while q_full is dropped; the stall unit guarantees id_advance=0 in that case.
- Resolve: when ex_resolve & count>0:
  - mispredict = head.pred ^ ex_taken.
  - Head is popped at the clock edge.
  - table[head.index] updates at that edge: increment saturating at 3 if ex_taken, else decrement saturating at 0.
- Resolve with count=0: mispredict=0, no update, underflow_err set until reset.
- Misprediction flush: when mispredict=1, the FIFO is emptied at that edge (all younger wrong-path entries discarded).
  - A push in the same cycle is also discarded; count becomes 0.
- Simultaneous push and pop without mispredict: count unchanged, pointers both advance (wrap modulo QDEPTH).
- Same-index read/update in one cycle: pred_taken uses the pre-update value (no bypass).
- q_full = (count==QDEPTH). A pop in the same cycle does not clear q_full early.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds outputs stat_branches[15:0] and stat_mispredicts[15:0].
  - stat_branches increments on each non-error resolve; stat_mispredicts increments on each resolve with mispredict=1.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then branch at id_pc=0x10 -> pred_taken=0 (counter 1). Resolve taken -> mispredict=1, counter 2. Same PC again -> pred_taken=1.
- Four resolves taken at index 5 -> counter saturates at 3. Two not-taken -> counter 1, pred_taken=0, no wrap.
- Push two branches (q_count=2, q_full=1), then a third with id_advance=0 -> no push. Resolve both correctly -> q_count=0, mispredict=0 each cycle.
- Two entries queued, head mispredicted while a third pushes in the same cycle -> mispredict=1, q_count=0 next cycle, only the head's counter changes.
- ex_resolve with empty FIFO -> mispredict=0, underflow_err=1 and stays 1; pulse rst=0 -> underflow_err=0, q_count=0, all counters 1.
- Same cycle: push at index 3 and resolve taken for index 3 (counter 1) -> pred_taken=0 that cycle; next lookup at index 3 gives pred_taken=1.
